kb_cmd_ctrl: RTL and testbench

- Consumer-side controller for the PS/2 key-code FIFO output of the keyboard receiver path.
- Pops released-key scan codes one at a time and translates them into 4-bit command codes.
- Suppresses repeated identical commands within a programmable hold-off window.
- Presents each command to the game/UI logic over a valid/ready handshake.

---
 rtl/kb_cmd_ctrl.sv | 86 ++++++++
 tb/tb_kb_cmd_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kb_cmd_ctrl.sv
// kb_cmd_ctrl: pops PS/2 scan codes, maps them to 4-bit commands with repeat hold-off, offers over valid/ready
module kb_cmd_ctrl #(
    parameter int HOLDOFF = 500000,
    parameter int HOLD_W  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] key_code,
    input  logic       kb_buf_empty,
    output logic       rd_key_code,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [3:0] cmd_code,
    output logic [7:0] unk_cnt
);
    typedef enum logic [1:0] {IDLE, DECODE, OFFER} state_t;
    state_t state, state_nx;
    logic [7:0] key_reg;
    logic [HOLD_W-1:0] hold;
    logic [3:0] last_cmd, map_code;
    logic last_ok, mapped, dup, accept;
    always_comb begin
        mapped = 1'b1;
        map_code = 4'h0;
        case (key_reg)
            8'h45: map_code = 4'h0;
            8'h16: map_code = 4'h1;
            8'h1E: map_code = 4'h2;
            8'h26: map_code = 4'h3;
            8'h25: map_code = 4'h4;
            8'h2E: map_code = 4'h5;
            8'h36: map_code = 4'h6;
            8'h3D: map_code = 4'h7;
            8'h3E: map_code = 4'h8;
            8'h46: map_code = 4'h9;
            8'h1D: map_code = 4'hA;
            8'h1B: map_code = 4'hB;
            8'h1C: map_code = 4'hC;
            8'h23: map_code = 4'hD;
            8'h5A: map_code = 4'hE;
            8'h76: map_code = 4'hF;
            default: mapped = 1'b0;
        endcase
    end
    // A repeat is only suppressed while the hold-off window is still running
    assign dup = last_ok && map_code == last_cmd && hold != '0;
    assign accept = state == OFFER && cmd_ready;
    assign rd_key_code = !reset && state == IDLE && en && !kb_buf_empty;
    assign cmd_valid = state == OFFER;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = rd_key_code ? DECODE : IDLE;
            DECODE:  state_nx = (mapped && !dup) ? OFFER : IDLE;
            OFFER:   state_nx = cmd_ready ? IDLE : OFFER;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            key_reg  <= 8'h00;
            cmd_code <= 4'h0;
            unk_cnt  <= 8'h00;
            hold     <= '0;
            last_cmd <= 4'h0;
            last_ok  <= 1'b0;
        end else begin
            state <= state_nx;
            if (rd_key_code)
                key_reg <= key_code;
            if (state == DECODE && mapped && !dup)
                cmd_code <= map_code;
            if (state == DECODE && !mapped && unk_cnt != 8'hFF)
                unk_cnt <= unk_cnt + 8'd1;
            if (accept) begin
                last_cmd <= cmd_code;
                last_ok  <= 1'b1;
                hold     <= HOLD_W'(HOLDOFF);
            end else if (hold != '0) begin
                hold <= hold - HOLD_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_kb_cmd_ctrl.sv
// tb_kb_cmd_ctrl: randomized and directed bench with a transaction-level model of the command controller
module tb_kb_cmd_ctrl;
    localparam int HOLDOFF = 8;
    logic clk = 0, reset = 0, en = 0, kb_buf_empty = 1, cmd_ready = 0;
    logic rd_key_code, cmd_valid;
    logic [7:0] key_code = 8'h00, unk_cnt;
    logic [3:0] cmd_code;
    logic [7:0] fifo[$];
    int lut[256];
    int errors = 0, checks = 0, pop_cnt = 0, acc_cnt = 0;
    bit pop_now = 0;
    bit m_dec, m_valid, m_last_ok, exp_rd;
    int m_cmd, m_key, m_unk, m_last, code;
    longint cyc = 0, m_acc = 0;

    always #5 clk = ~clk;

    kb_cmd_ctrl #(.HOLDOFF(HOLDOFF), .HOLD_W(5)) dut (
        .clk(clk), .reset(reset), .en(en), .key_code(key_code), .kb_buf_empty(kb_buf_empty),
        .rd_key_code(rd_key_code), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .unk_cnt(unk_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        kb_buf_empty = fifo.size() == 0;
        key_code = kb_buf_empty ? 8'h00 : fifo[0];
    endtask

    task automatic push(input logic [7:0] c);
        fifo.push_back(c);
        drive_fifo();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1;
        tick(2);
        reset = 0;
        tick(1);
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        while (cmd_valid !== 1'b1 && k < 100) begin
            tick(1);
            k++;
        end
        chk(nm, cmd_valid, 1);
    endtask

    task automatic drain();
        int k = 0;
        while (fifo.size() != 0 && k < 3000) begin
            tick(1);
            k++;
        end
        chk("drain", fifo.size() == 0, 1);
        tick(4);
    endtask

    // FIFO side of the environment: pops the head after the edge that consumed it
    always @(posedge clk) begin
        #1;
        if (pop_now && fifo.size() != 0) begin
            void'(fifo.pop_front());
            pop_cnt++;
        end
        pop_now = 0;
        drive_fifo();
    end

    // Model: fetch when free, decode one cycle later, offer until accepted
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            m_dec = 0; m_valid = 0; m_cmd = 0; m_unk = 0; m_last_ok = 0;
            chk("rst_rd", rd_key_code, 0);
            chk("rst_valid", cmd_valid, 0);
            chk("rst_code", cmd_code, 0);
            chk("rst_unk", unk_cnt, 0);
        end else begin
            exp_rd = !m_dec && !m_valid && en && fifo.size() != 0;
            chk("rd", rd_key_code, exp_rd);
            chk("valid", cmd_valid, m_valid);
            chk("code", cmd_code, m_cmd);
            chk("unk", unk_cnt, m_unk);
            if (m_valid) begin
                if (cmd_ready) begin
                    m_valid = 0; m_last = m_cmd; m_last_ok = 1; m_acc = cyc;
                    acc_cnt++;
                end
            end else if (m_dec) begin
                m_dec = 0;
                code = lut[m_key];
                if (code < 0)
                    m_unk = m_unk < 255 ? m_unk + 1 : 255;
                else if (!(m_last_ok && code == m_last && cyc - m_acc <= HOLDOFF)) begin
                    m_cmd = code;
                    m_valid = 1;
                end
            end else if (exp_rd) begin
                m_key = int'(fifo[0]);
                m_dec = 1;
            end
        end
        pop_now = rd_key_code;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p, a;
        logic [7:0] picks[9];
        picks = '{8'h23, 8'h23, 8'h1C, 8'h16, 8'h45, 8'h5A, 8'h00, 8'hF0, 8'h76};
        foreach (lut[i]) lut[i] = -1;
        lut[8'h45] = 0; lut[8'h16] = 1; lut[8'h1E] = 2; lut[8'h26] = 3; lut[8'h25] = 4;
        lut[8'h2E] = 5; lut[8'h36] = 6; lut[8'h3D] = 7; lut[8'h3E] = 8; lut[8'h46] = 9;
        lut[8'h1D] = 10; lut[8'h1B] = 11; lut[8'h1C] = 12; lut[8'h23] = 13; lut[8'h5A] = 14; lut[8'h76] = 15;
        drive_fifo();
        #1 reset = 1;
        tick(3);
        chk("reset_valid", cmd_valid, 0);
        chk("reset_unk", unk_cnt, 0);
        reset = 0;
        tick(1);
        // reset while a command is being offered
        en = 1; cmd_ready = 0;
        push(8'h1D);
        wait_valid("t1_offer");
        chk("t1_code_a", cmd_code, 4'hA);
        tick(2);
        reset = 1;
        #1;
        chk("t1_async_valid", cmd_valid, 0);
        chk("t1_async_code", cmd_code, 0);
        chk("t1_async_unk", unk_cnt, 0);
        p = pop_cnt;
        tick(3);
        chk("t1_no_pop", pop_cnt, p);
        reset = 0;
        cmd_ready = 1;
        push(8'h5A);
        wait_valid("t1_after");
        chk("t1_code_e", cmd_code, 4'hE);
        drain();
        // single key latency
        do_reset();
        push(8'h16);
        #1;
        chk("t2_rd_n", rd_key_code, 1);
        chk("t2_valid_n", cmd_valid, 0);
        tick(1);
        chk("t2_rd_n1", rd_key_code, 0);
        chk("t2_valid_n1", cmd_valid, 0);
        tick(1);
        chk("t2_valid_n2", cmd_valid, 1);
        chk("t2_code_n2", cmd_code, 4'h1);
        tick(1);
        chk("t2_valid_n3", cmd_valid, 0);
        // backpressure
        cmd_ready = 0;
        p = pop_cnt;
        push(8'h1D);
        push(8'h1B);
        tick(12);
        chk("t3_one_pop", pop_cnt, p + 1);
        chk("t3_held_valid", cmd_valid, 1);
        chk("t3_held_code", cmd_code, 4'hA);
        cmd_ready = 1;
        tick(1);
        wait_valid("t3_second");
        chk("t3_code_b", cmd_code, 4'hB);
        chk("t3_two_pops", pop_cnt, p + 2);
        drain();
        // hold-off window
        tick(12);
        a = acc_cnt;
        push(8'h23);
        push(8'h23);
        drain();
        chk("t4_dup_dropped", acc_cnt, a + 1);
        tick(10);
        push(8'h23);
        drain();
        chk("t4_after_window", acc_cnt, a + 2);
        tick(10);
        push(8'h23);
        push(8'h1C);
        drain();
        chk("t4_distinct", acc_cnt, a + 4);
        // unmapped codes
        a = acc_cnt;
        push(8'h00);
        push(8'h12);
        push(8'h99);
        drain();
        chk("t5_unk3", unk_cnt, 3);
        chk("t5_no_cmd", acc_cnt, a);
        for (int i = 0; i < 260; i++) push(8'h80 | 8'($urandom_range(0, 127)));
        drain();
        chk("t5_sat", unk_cnt, 255);
        // enable gating
        en = 0;
        p = pop_cnt;
        push(8'h16);
        tick(20);
        chk("t6_gated_pop", pop_cnt, p);
        chk("t6_gated_valid", cmd_valid, 0);
        en = 1;
        wait_valid("t6_fetch");
        chk("t6_code", cmd_code, 4'h1);
        tick(2);
        cmd_ready = 0;
        push(8'h25);
        wait_valid("t6_offer");
        en = 0;
        tick(3);
        a = acc_cnt;
        cmd_ready = 1;
        tick(2);
        chk("t6_completed", acc_cnt, a + 1);
        chk("t6_code4", cmd_code, 4'h4);
        en = 1;
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            tick(1);
            reset = $urandom_range(0, 249) == 0;
            if (fifo.size() < 6 && $urandom_range(0, 2) == 0) push(picks[$urandom_range(0, 8)]);
            en = $urandom_range(0, 3) != 0;
            cmd_ready = $urandom_range(0, 1) == 1;
        end
        reset = 0; en = 1; cmd_ready = 1;
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
